// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// seq_divider: 16-bit unsigned restoring divider that produces one quotient bit
// per clock. It runs freely: any change on the operand inputs, or the first
// cycle after reset, captures the operand pair and starts a new division.
// out_result packs {remainder, quotient}, and out_done qualifies it.
// Optional feature macro: SEQ_DIVIDER_DIVZERO_ERR_EN adds the out_err
// divide-by-zero flag.
module seq_divider (
  input  logic        inp_clk,
  input  logic        inp_rst,
  input  logic [15:0] inp_a,
  input  logic [15:0] inp_b,
  output logic        out_done,
  output logic [31:0] out_result
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
  ,
  output logic        out_err
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic        valid;
  logic [4:0]  cnt;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic [15:0] rem;
  logic [15:0] quo;
  logic        start;
  logic [15:0] rem_nxt;
  logic [15:0] quo_nxt;

  // One restoring step. The trial value is 17 bits wide, so the bit that is
  // shifted out of the remainder takes part in the compare. The partial
  // remainder is always below the divisor, or is a prefix of the dividend
  // when the divisor is zero, so the stored remainder fits in 16 bits.
  function automatic logic [31:0] div_step(input logic [15:0] r,
                                           input logic [15:0] q,
                                           input logic [15:0] d);
    logic [16:0] t;
    logic [16:0] diff;
    logic        qbit;
    t    = {r, q[15]};
    qbit = (t >= {1'b0, d});
    diff = qbit ? (t - {1'b0, d}) : t;
    return {diff[15:0], q[14:0], qbit};
  endfunction

  assign start = !valid || (inp_a != cap_a) || (inp_b != cap_b);
  assign {rem_nxt, quo_nxt} = div_step(rem, quo, cap_b);

  // Control: operand capture, iteration count, FSM and result/done outputs
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state      <= IDLE;
      valid      <= 1'b0;
      cnt        <= 5'd0;
      cap_a      <= 16'd0;
      cap_b      <= 16'd0;
      out_done   <= 1'b0;
      out_result <= 32'd0;
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
      out_err    <= 1'b0;
`endif
    end else if (start) begin
      cap_a    <= inp_a;
      cap_b    <= inp_b;
      valid    <= 1'b1;
      cnt      <= 5'd16;
      out_done <= 1'b0;
      state    <= BUSY;
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
      out_err  <= 1'b0;
`endif
    end else if (state == BUSY) begin
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        out_result <= {rem_nxt, quo_nxt};
        out_done   <= 1'b1;
        state      <= IDLE;
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
        out_err    <= (cap_b == 16'd0);
`endif
      end
    end
  end

  // Datapath: the partial remainder and quotient shift register. A start
  // always reloads them, so they need no reset.
  always_ff @(posedge inp_clk) begin
    if (start) begin
      rem <= 16'd0;
      quo <= inp_a;
    end else if (state == BUSY) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
// Directed testbench for seq_divider. It applies a table of operand pairs and
// then runs hand-written abort and reset sequences.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        done;
  logic [31:0] result;
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  always #2 clk = ~clk;

  seq_divider dut (
    .inp_clk   (clk),
    .inp_rst   (rst),
    .inp_a     (a),
    .inp_b     (b),
    .out_done  (done),
    .out_result(result)
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
    ,
    .out_err   (err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits for the capture edge, which must clear done, and then counts the
  // edges until done rises. A value of 41 means the wait timed out.
  task automatic wait_done(output int lat);
    @(posedge clk); #1;
    chk("done_low_after_capture", {31'd0, done}, 32'd0);
    lat = 41;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic early;

    vecs[0] = '{16'd30576, 16'd16,    32'h0000_0777, 1'b0};
    vecs[1] = '{16'd30578, 16'd16,    32'h0002_0777, 1'b0};
    vecs[2] = '{16'd99,    16'd7,     32'h0001_000E, 1'b0};
    vecs[3] = '{16'd1234,  16'd0,     32'h04D2_FFFF, 1'b1};
    vecs[4] = '{16'd65535, 16'd1,     32'h0000_FFFF, 1'b0};
    vecs[5] = '{16'd0,     16'd5,     32'h0000_0000, 1'b0};
    vecs[6] = '{16'd7,     16'd65535, 32'h0007_0000, 1'b0};
    vecs[7] = '{16'd65535, 16'd65535, 32'h0000_0001, 1'b0};
    vecs[8] = '{16'd65535, 16'd0,     32'hFFFF_FFFF, 1'b1};

    rst = 1'b1;
    a   = 16'd0;
    b   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
    chk("reset_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd16);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
`ifdef SEQ_DIVIDER_DIVZERO_ERR_EN
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
`endif
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("vec%0d_hold_result", i), result, vecs[i].res);
    end

    // Abort: the operands change 8 cycles into a division.
    a = 16'd65535;
    b = 16'd1;
    @(posedge clk); #1;
    early = done;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      early = early | done;
    end
    chk("abort_no_done", {31'd0, early}, 32'd0);
    a = 16'd100;
    b = 16'd3;
    wait_done(lat);
    chk("abort_latency", lat, 32'd16);
    chk("abort_result", result, 32'h0001_0021);
    repeat (8) @(posedge clk);
    #1;

    // Reset mid-BUSY, then release: the held operands are recomputed.
    a = 16'd1000;
    b = 16'd9;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(lat);
    chk("midrst_latency", lat, 32'd16);
    chk("midrst_recomputed", result, 32'h0001_006F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
